// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: forward-select encodings, pipeline register
// layouts and the forwarding-priority helper used by the memory stage.
package mips_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int unsigned DMEM_WORDS_DEFAULT = 256;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] load_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } mem_wb_t;

    // A load still in EX/MEM has no data yet, so it never forwards from there.
    function automatic logic [1:0] fwd_select(input logic [4:0] src,
                                              input logic       em_reg_write,
                                              input logic       em_mem_read,
                                              input logic [4:0] em_rd,
                                              input logic       mw_reg_write,
                                              input logic [4:0] mw_rd);
        if (em_reg_write && !em_mem_read && (em_rd != 5'd0) && (em_rd == src))
            return FWD_EXMEM;
        else if (mw_reg_write && (mw_rd != 5'd0) && (mw_rd == src))
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/mem_stage_dmem.sv
// Word-wide data memory: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module dmem #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM and MEM/WB pipeline registers, data memory access
// with misalignment trapping, and EX-stage operand forwarding selects.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  id_ex_rs,
    input  logic [4:0]  id_ex_rt,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_to_reg,
    input  logic        ex_bubble,
    output logic [31:0] EX_MEMALUres,
    output logic [31:0] MEM_WBres,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [1:0]  FA,
    output logic [1:0]  FB,
    output logic        misalign_err
);

    localparam int unsigned AW = $clog2(DMEM_WORDS);

    ex_mem_t       ex_mem;
    mem_wb_t       mem_wb;
    logic          misaligned;
    logic          mem_access;
    logic          mem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_rdata;
    logic [31:0]   load_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem <= '0;
        end else begin
            ex_mem.alu_res    <= ex_alu_res;
            ex_mem.store_data <= ex_store_data;
            ex_mem.rd         <= ex_rd;
            ex_mem.reg_write  <= ex_reg_write & ~ex_bubble & (ex_rd != 5'd0);
            ex_mem.mem_read   <= ex_mem_read & ~ex_bubble;
            ex_mem.mem_write  <= ex_mem_write & ~ex_bubble;
            ex_mem.mem_to_reg <= ex_mem_to_reg & ~ex_bubble;
        end
    end

    assign misaligned = (ex_mem.alu_res[1:0] != 2'b00);
    assign mem_access = ex_mem.mem_read | ex_mem.mem_write;
    assign dmem_addr  = ex_mem.alu_res[AW+1:2];
    // rst clears ex_mem.mem_write asynchronously, so no store can land during reset.
    assign mem_we     = ex_mem.mem_write & ~misaligned;
    assign load_data  = misaligned ? '0 : dmem_rdata;

    dmem #(
        .WORDS (DMEM_WORDS)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (dmem_addr),
        .wdata (ex_mem.store_data),
        .rdata (dmem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_err <= 1'b0;
        else if (mem_access && misaligned)
            misalign_err <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb <= '0;
        end else begin
            mem_wb.alu_res    <= ex_mem.alu_res;
            mem_wb.load_data  <= load_data;
            mem_wb.rd         <= ex_mem.rd;
            mem_wb.reg_write  <= ex_mem.reg_write;
            mem_wb.mem_to_reg <= ex_mem.mem_to_reg;
        end
    end

    assign EX_MEMALUres = ex_mem.alu_res;
    assign MEM_WBres    = mem_wb.mem_to_reg ? mem_wb.load_data : mem_wb.alu_res;
    assign wb_rd        = mem_wb.rd;
    assign wb_reg_write = mem_wb.reg_write;

    assign FA = fwd_select(id_ex_rs, ex_mem.reg_write, ex_mem.mem_read, ex_mem.rd,
                           mem_wb.reg_write, mem_wb.rd);
    assign FB = fwd_select(id_ex_rt, ex_mem.reg_write, ex_mem.mem_read, ex_mem.rd,
                           mem_wb.reg_write, mem_wb.rd);

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DMEM_WORDS, default 256, number of 32-bit data-memory words (power of two).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ex_alu_res  input  32  ALU result from execute stage (address for load/store).
REQ-005 ex_store_data  input  32  forwarded second operand (store data).
REQ-006 ex_rd, id_ex_rs, id_ex_rt  input  5 each  destination of EX instruction; sources of instruction now entering EX.
REQ-007 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  input  1 each  control bits of EX instruction.
REQ-008 ex_bubble  input  1  loads a no-op into EX/MEM this edge.
REQ-009 EX_MEMALUres  output  32  EX/MEM registered ALU result (forward path).
REQ-010 MEM_WBres  output  32  write-back value (forward path and register-file write data).
REQ-011 wb_rd / wb_reg_write  output  5 / 1  register-file write address and enable.
REQ-012 FA, FB  output  2 each  forward selects: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-013 misalign_err  output  1  sticky misaligned-access flag.

Function
REQ-014 EX/MEM register SHALL capture ex_* inputs on each rising edge; with ex_bubble=1 all its control bits SHALL be captured as 0.
REQ-015 A captured reg_write SHALL be forced to 0 when ex_rd=0.
REQ-016 Data memory SHALL be word-addressed by EX/MEM address bits [log2(DMEM_WORDS)+1:2]; upper bits ignored (wrap-around).
REQ-017 Store SHALL write EX/MEM store data at the rising edge ending the MEM cycle; load read SHALL be combinational in the MEM cycle.
REQ-018 Access with address[1:0]!=0 SHALL suppress the write, return 0 for loads, and set misalign_err; it stays set until reset.
REQ-019 MEM/WB register SHALL capture ALU result, load data, rd, reg_write, mem_to_reg on each rising edge.
REQ-020 MEM_WBres SHALL equal MEM/WB load data when mem_to_reg=1, else MEM/WB ALU result.
REQ-021 Latency: input at edge N -> EX_MEMALUres after N; MEM_WBres, wb_* after N+1.
REQ-022 Store at edge N followed by load of same word in the next instruction SHALL return the new data.
REQ-023 FA=10 when EX/MEM reg_write=1, mem_read=0, rd!=0, rd=id_ex_rs; else FA=01 when MEM/WB reg_write=1, rd!=0, rd=id_ex_rs; else 00. FB identical using id_ex_rt.
REQ-024 EX/MEM match SHALL take priority over MEM/WB match.
REQ-025 FA/FB SHALL be combinational from the pipeline registers and the id_ex_* inputs.

Reset
REQ-026 rst=1 SHALL immediately clear EX/MEM and MEM/WB registers (all outputs 0, FA=FB=00) and misalign_err.
REQ-027 Data-memory contents SHALL NOT be reset.
REQ-028 A store in MEM when rst asserts SHALL NOT write memory.

Structure
REQ-029 Shared package mips_pkg SHALL hold FWD_REG=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01 and the default DMEM_WORDS.
REQ-030 Data memory SHALL be a sub-module dmem (one write port, one async read port).

Verification
REQ-031 Store 0xDEADBEEF to 0x10, then load 0x10 -> MEM_WBres=0xDEADBEEF two edges after load input.
REQ-032 ALU op rd=5 result 0x1234, next id_ex_rs=5 -> FA=10; one cycle later FA=01; rd=0 -> FA=00.
REQ-033 EX/MEM and MEM/WB both rd=7, id_ex_rt=7 -> FB=10.
REQ-034 Store to 0x13 -> memory unchanged, misalign_err=1, remains 1 until rst.
REQ-035 ex_bubble=1 on a store -> no write, wb_reg_write=0 next cycle.
REQ-036 rst asserted mid-stream between edges -> all outputs 0 immediately; memory keeps prior data.
